// File: rtl/sad_vector_gen_if.sv
// Pixel-pair input stream and SAD-vector output stream of sad_vector_gen.
// The master drives the pixel stream and receives the cost vectors.
interface sad_vector_gen_if #(
  parameter int ELEM       = 64,
  parameter int DATA_WIDTH = 8,
  parameter int PIX_WIDTH  = 8
);
  logic                               i_valid;
  logic                               i_sol;
  logic [PIX_WIDTH-1:0]               i_left;
  logic [PIX_WIDTH-1:0]               i_right;
  logic                               o_valid;
  logic                               o_sol;
  logic [ELEM-1:0][DATA_WIDTH-1:0]    o_sads_data;

  modport master (
    output i_valid, i_sol, i_left, i_right,
    input  o_valid, o_sol, o_sads_data
  );

  modport slave (
    input  i_valid, i_sol, i_left, i_right,
    output o_valid, o_sol, o_sads_data
  );
endinterface

// File: rtl/sad_vector_gen.sv
// Per-pixel window SAD cost vector over disparities 0..ELEM-1 (ELEM >= 2).
// Three stages: absolute difference, sliding-window sum, saturation.
module sad_vector_gen #(
  parameter int ELEM       = 64,
  parameter int DATA_WIDTH = 8,
  parameter int PIX_WIDTH  = 8,
  parameter int WIN        = 8
) (
  input  logic            aclk,
  input  logic            aresetn,
  sad_vector_gen_if.slave bus
);
  localparam int ACC_W   = PIX_WIDTH + $clog2(WIN) + 1;
  localparam int COL_W   = $clog2(ELEM);
  localparam int OW      = (ACC_W > DATA_WIDTH) ? ACC_W : DATA_WIDTH;
  localparam int MAX_OUT = (1 << DATA_WIDTH) - 1;

  typedef logic [PIX_WIDTH-1:0] pix_t;
  typedef logic [ACC_W-1:0]     acc_t;

  // r_q[i] holds R[x-1-i] for the next pixel x; r_pos[d] is R[x-d].
  pix_t             r_q   [ELEM-1];
  pix_t             r_pos [ELEM];
  logic [COL_W-1:0] col_q, col_d;
  logic             started_q;

  pix_t             ad_d [ELEM];
  pix_t             ad_q [ELEM];
  logic             v1_q, s1_q;

  pix_t             hist_q [ELEM][WIN];
  acc_t             acc_q  [ELEM];
  logic             v2_q, s2_q;

  logic [ELEM-1:0][DATA_WIDTH-1:0] out_q;
  logic             v3_q, s3_q;

  function automatic logic [DATA_WIDTH-1:0] sat(input acc_t a);
    logic [OW-1:0] e;
    e = OW'(a);
    if (e > OW'(MAX_OUT)) return '1;
    return e[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    r_pos[0] = bus.i_right;
    for (int d = 1; d < ELEM; d++) r_pos[d] = r_q[d-1];
  end

  // Column of the pixel currently offered; the first pixel after reset is column 0.
  always_comb begin
    col_d = col_q;
    if (bus.i_sol || !started_q)         col_d = '0;
    else if (col_q != COL_W'(ELEM - 1))  col_d = col_q + 1'b1;
  end

  always_comb begin
    logic [PIX_WIDTH:0] diff;
    logic [PIX_WIDTH:0] mag;
    for (int d = 0; d < ELEM; d++) begin
      diff = {1'b0, bus.i_left} - {1'b0, r_pos[d]};
      mag  = diff[PIX_WIDTH] ? (~diff + 1'b1) : diff;
      ad_d[d] = (COL_W'(d) <= col_d) ? mag[PIX_WIDTH-1:0] : '1;
    end
  end

  // NOTE: the delay lines and accumulators are reset because a cleared history is what
  // makes the first pixel after reset behave as column 0 with no sol marker.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < ELEM - 1; i++) r_q[i] <= '0;
      col_q     <= '0;
      started_q <= 1'b0;
    end else if (bus.i_valid) begin
      r_q[0] <= bus.i_right;
      for (int i = 1; i < ELEM - 1; i++) r_q[i] <= bus.i_sol ? '0 : r_q[i-1];
      col_q     <= col_d;
      started_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int d = 0; d < ELEM; d++) ad_q[d] <= '0;
      v1_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      v1_q <= bus.i_valid;
      s1_q <= bus.i_valid & bus.i_sol;
      if (bus.i_valid) ad_q <= ad_d;
    end
  end

  // Accumulator tracks the sum of its history; a sol sample restarts both.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int d = 0; d < ELEM; d++) begin
        acc_q[d] <= '0;
        for (int w = 0; w < WIN; w++) hist_q[d][w] <= '0;
      end
      v2_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      s2_q <= s1_q;
      if (v1_q) begin
        for (int d = 0; d < ELEM; d++) begin
          hist_q[d][0] <= ad_q[d];
          if (s1_q) begin
            acc_q[d] <= ACC_W'(ad_q[d]);
            for (int w = 1; w < WIN; w++) hist_q[d][w] <= '0;
          end else begin
            acc_q[d] <= acc_q[d] + ACC_W'(ad_q[d]) - ACC_W'(hist_q[d][WIN-1]);
            for (int w = 1; w < WIN; w++) hist_q[d][w] <= hist_q[d][w-1];
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_q <= '0;
      v3_q  <= 1'b0;
      s3_q  <= 1'b0;
    end else begin
      v3_q <= v2_q;
      s3_q <= s2_q;
      if (v2_q) begin
        for (int d = 0; d < ELEM; d++) out_q[d] <= sat(acc_q[d]);
      end
    end
  end

  assign bus.o_valid     = v3_q;
  assign bus.o_sol       = s3_q;
  assign bus.o_sads_data = out_q;
endmodule

// File: tb/tb_sad_vector_gen.sv
// Self-checking bench for sad_vector_gen: directed rows plus random traffic,
// compared against a row-buffer model that sums window costs directly.
module tb_sad_vector_gen;
  localparam int ELEM = 4;
  localparam int DW   = 8;
  localparam int PW   = 8;
  localparam int WIN  = 3;
  localparam int VW   = ELEM * DW;

  typedef struct {
    logic          sol;
    logic [VW-1:0] vec;
  } exp_t;

  logic aclk;
  logic aresetn;

  sad_vector_gen_if #(.ELEM(ELEM), .DATA_WIDTH(DW), .PIX_WIDTH(PW)) bus ();

  sad_vector_gen #(.ELEM(ELEM), .DATA_WIDTH(DW), .PIX_WIDTH(PW), .WIN(WIN)) u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int            n_vec = 0;
  int            n_err = 0;
  exp_t          exp_q [$];
  int            lq [$];
  int            rq [$];
  bit            fresh = 1'b1;
  logic [2:0]    vp;
  logic [VW-1:0] last_data = '0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: keep the whole current row and sum the last WIN columns per disparity.
  task automatic model_push(input logic s, input int l, input int r);
    exp_t e;
    int   p, lo, sum, ad;
    if (s || fresh) begin
      lq.delete();
      rq.delete();
      fresh = 1'b0;
    end
    lq.push_back(l);
    rq.push_back(r);
    p  = lq.size() - 1;
    lo = (p - WIN + 1 < 0) ? 0 : p - WIN + 1;
    e.sol = s;
    e.vec = '0;
    for (int d = 0; d < ELEM; d++) begin
      sum = 0;
      for (int j = lo; j <= p; j++) begin
        if (j >= d) begin
          ad = lq[j] - rq[j-d];
          if (ad < 0) ad = -ad;
        end else begin
          ad = 255;
        end
        sum += ad;
      end
      e.vec[d*DW +: DW] = (sum > 255) ? 8'd255 : 8'(sum);
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic s, input int l, input int r);
    @(negedge aclk);
    #1;
    bus.i_valid = v;
    bus.i_sol   = s;
    bus.i_left  = PW'(l);
    bus.i_right = PW'(r);
    if (v) model_push(s, l, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
  endtask

  // Input valid delayed by the pipeline depth, used to check the o_valid pattern.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) vp <= '0;
    else          vp <= {vp[1:0], bus.i_valid};
  end

  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      check("rst_o_valid", 64'(bus.o_valid), 64'(0));
      check("rst_o_sol", 64'(bus.o_sol), 64'(0));
      check("rst_o_sads", 64'(bus.o_sads_data), 64'(0));
      last_data = '0;
    end else begin
      check("o_valid_delay", 64'(bus.o_valid), 64'(vp[2]));
      if (bus.o_valid) begin
        check("o_valid_expected", 64'(bus.o_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("o_sol", 64'(bus.o_sol), 64'(e.sol));
          check("o_sads", 64'(bus.o_sads_data), 64'(e.vec));
        end
        last_data = bus.o_sads_data;
      end else begin
        check("hold_o_sads", 64'(bus.o_sads_data), 64'(last_data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v;
    aresetn     = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_sol   = 1'b0;
    bus.i_left  = '0;
    bus.i_right = '0;

    repeat (4) @(negedge aclk);
    #1 aresetn = 1'b1;
    idle(3);

    // Constant equal row: invalid disparities saturate early columns.
    for (int x = 0; x < 8; x++) drive(1'b1, x == 0, 10, 10);

    // Right image shifted by two: d2 settles to zero.
    for (int x = 0; x < 8; x++) drive(1'b1, x == 0, (x >= 2) ? 20 * (x - 2) : 0, 20 * x);

    // Saturation: raw window sums exceed the output range.
    for (int x = 0; x < 6; x++) drive(1'b1, x == 0, 255, 0);

    // Asynchronous reset while outputs are valid and nonzero.
    @(posedge aclk);
    #3 aresetn = 1'b0;
    #1;
    check("async_o_valid", 64'(bus.o_valid), 64'(0));
    check("async_o_sol", 64'(bus.o_sol), 64'(0));
    check("async_o_sads", 64'(bus.o_sads_data), 64'(0));
    bus.i_valid = 1'b0;
    exp_q.delete();
    fresh = 1'b1;
    repeat (2) @(negedge aclk);
    #1 aresetn = 1'b1;
    idle(2);

    // Equal row again, with a 1,0,0 valid pattern.
    v = 0;
    for (int c = 0; v < 8; c++) begin
      if (c % 3 == 0) begin
        drive(1'b1, v == 0, 10, 10);
        v++;
      end else begin
        drive(1'b0, 1'b0, 10, 10);
      end
    end
    idle(2);

    // Shifted row interrupted by a new sol after six pixels.
    for (int x = 0; x < 10; x++)
      drive(1'b1, (x == 0) || (x == 6), (x >= 2) ? 20 * (x - 2) : 0, 20 * x);

    // Random traffic: gaps, unqualified sol, restarts, arbitrary pixels.
    for (int i = 0; i < 300; i++)
      drive(($urandom % 4) != 0, ($urandom % 10) == 0,
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

    idle(4);
    check("drain", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sad_vector_gen.md
Name: sad_vector_gen

Overview:
- Produces the per-pixel vector of window SAD costs, one cost per candidate disparity, for the downstream argmin/disparity stage (Min_Arg).
- Consumes a rectified left/right pixel stream in raster order, one pixel pair per accepted cycle.
- Computes absolute differences for disparities 0..ELEM-1 and sums each over a horizontal window of WIN pixels.
- Emits one saturated ELEM x DATA_WIDTH packed vector per accepted input pixel.

Parameters:
ELEM, 64, number of disparity candidates (vector length, same meaning as the downstream argmin stage)
DATA_WIDTH, 8, width of each output SAD element
PIX_WIDTH, 8, width of each input pixel
WIN, 8, horizontal window length in pixels (>=1)

Ports:
aclk  input  1  clock, all logic on rising edge
aresetn  input  1  asynchronous active-low reset
i_valid  input  1  pixel pair valid; pipeline advances only on cycles with i_valid=1
i_sol  input  1  start of line, qualified by i_valid; marks column 0 of a row
i_left  input  PIX_WIDTH  left-image pixel L[x]
i_right  input  PIX_WIDTH  right-image pixel R[x]
o_valid  output  1  output vector valid
o_sol  output  1  start of line, aligned with o_valid
o_sads_data  output  ELEM*DATA_WIDTH  packed [ELEM-1:0][DATA_WIDTH-1:0]; element d = cost for disparity d

Behaviour:
- Reset (aresetn=0, async): o_valid=0, o_sol=0, o_sads_data=0. Right shift register, AD history, accumulators, column counter and pipeline valids all cleared. Applies mid-row as well; the first accepted pixel after reset is treated as column 0 whether or not i_sol is set.
- Right shift register, ELEM deep:
  - On an accepted pixel, position 0 takes R[x] and position d takes R[x-d].
  - When i_sol=1, every position above 0 is cleared in the same cycle.
- Column counter col:
  - Set to 0 on an accepted i_sol pixel, otherwise incremented per accepted pixel.
  - Saturates at ELEM-1.
  - Disparity d is valid iff d <= col.
- Stage 1 (edge of acceptance k):
  - AD_d = |L[x] - R[x-d]|, computed unsigned at PIX_WIDTH+1 bits.
  - An invalid disparity forces AD_d = 2^PIX_WIDTH-1 (maximum cost).
  - Registered along with valid and sol.
- Stage 2 (edge k+1):
  - Per d, a WIN-deep AD history and an accumulator of width PIX_WIDTH+clog2(WIN)+1.
  - Update: acc_d <= acc_d + AD_new - AD_oldest; history shifts.
  - On a sol-tagged sample: acc_d <= AD_new and the history is cleared to zeros before the push, so early columns sum over a partial window.
  - History and accumulators hold on bubbles.
- Stage 3 (edge k+2):
  - o_sads_data[d] = min(acc_d, 2^DATA_WIDTH-1), saturated, never wrapped.
  - o_valid and o_sol are the delayed stage tags.
- Latency: input accepted at edge k appears at edge k+2. Throughput is one vector per cycle.
- Bubbles: i_valid=0 cycles freeze all state; no pipeline collapse is required. o_valid mirrors the input valid pattern with a 2-cycle delay, and o_sads_data holds its last value while o_valid=0.
- Input qualification: i_sol with i_valid=0 is ignored. Two consecutive sol pixels each restart the row.
- No backpressure: the downstream stage must accept every o_valid cycle.

Test Plan (ELEM=4, WIN=3, PIX_WIDTH=8, DATA_WIDTH=8):
1. Reset held then released, no input:
   - o_valid=0, o_sol=0, o_sads_data=0 on every cycle.
   - Asserting aresetn=0 mid-stream clears the outputs asynchronously, without waiting for a clock edge.
2. L=R=10 constant row of 8 pixels starting with i_sol, i_valid continuous:
   - Column 0 output = [0,255,255,255] (d0..d3) with o_sol=1, 2 cycles after input.
   - Column 1 = [0,255,255,255], saturated.
   - From column 5 onward = [0,0,0,0].
3. R[x]=20x, L[x]=R[x-2] for x>=2 (L=0 for x<2), one row:
   - From column 4, element d2=0.
   - Elements d0, d1, d3 are nonzero (d0=120 at column 4, i.e. 40*3).
4. Saturation, L=255, R=0 constant:
   - Every element = 255 at every column, with no wrap (the raw d0 sum of 765 clamps to 255).
5. Case 2 stimulus with i_valid toggled 1,0,0,1,...:
   - Output values are identical to the continuous run.
   - o_valid reproduces the input gap pattern delayed by 2 cycles.
   - o_sads_data is stable during the gaps.
6. New i_sol mid-row after 6 pixels of case 3:
   - The next output restarts at column-0 behaviour: d1..d3 = 255, d0 = |L-R| only.
   - No carry-over from the previous row's history.
